// File: rtl/hazard_unit_mdu.sv
// hazard_unit_mdu: hazard controller for the 5-stage pipelined MIPS core.
// Produces E-stage operand forwarding from M/W, D-stage branch forwarding from M,
// load-use, branch-compare and MDU-busy stalls, and the IF-ID / ID-EX flushes.
// A countdown tracks the multi-cycle mult/div unit so HI/LO consumers wait.
// Optional feature macro: HAZARD_PERF_EN adds saturating stall/flush counters
// with a synchronous clear (PerfClr, StallCnt, FlushCnt).
// Reset is synchronous, active low (rst_n).

module hazard_unit_mdu #(
    parameter int REG_ADDR_W  = 5,
    parameter int MDU_LATENCY = 32,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] RsD,
    input  logic [REG_ADDR_W-1:0] RtD,
    input  logic [REG_ADDR_W-1:0] RsE,
    input  logic [REG_ADDR_W-1:0] RtE,
    input  logic [REG_ADDR_W-1:0] WriteRegE,
    input  logic [REG_ADDR_W-1:0] WriteRegM,
    input  logic [REG_ADDR_W-1:0] WriteRegW,
    input  logic                  RegWriteE,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic                  MemtoRegE,
    input  logic                  MemtoRegM,
    input  logic                  BranchD,
    input  logic                  BranchTakenD,
    input  logic                  MduStartE,
    input  logic                  MduUseD,
`ifdef HAZARD_PERF_EN
    input  logic                  PerfClr,
    output logic [CNT_W-1:0]      StallCnt,
    output logic [CNT_W-1:0]      FlushCnt,
`endif
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  ForwardAD,
    output logic                  ForwardBD,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  MduBusy
);

    localparam int MDU_CNT_W = $clog2(MDU_LATENCY + 1);
    localparam logic [MDU_CNT_W-1:0] MDU_LOAD = MDU_CNT_W'(MDU_LATENCY);
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    logic [MDU_CNT_W-1:0] mdu_cnt_q;
    logic [MDU_CNT_W-1:0] mdu_cnt_d;

    logic hit_e_s;
    logic hit_m_s;
    logic lwstall_s;
    logic brstall_s;
    logic mdustall_s;
    logic stall_s;

    // E-stage operand forwarding: M result has priority over W; reg 0 never forwards
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if ((RsE != REG_ZERO) && (RsE == WriteRegM) && RegWriteM) begin
            ForwardAE = 2'b10;
        end else if ((RsE != REG_ZERO) && (RsE == WriteRegW) && RegWriteW) begin
            ForwardAE = 2'b01;
        end else begin
            ForwardAE = 2'b00;
        end
        if ((RtE != REG_ZERO) && (RtE == WriteRegM) && RegWriteM) begin
            ForwardBE = 2'b10;
        end else if ((RtE != REG_ZERO) && (RtE == WriteRegW) && RegWriteW) begin
            ForwardBE = 2'b01;
        end else begin
            ForwardBE = 2'b00;
        end
    end

    // D-stage branch operand forwarding from the M-stage ALU result
    always_comb begin
        ForwardAD = (RsD != REG_ZERO) && (RsD == WriteRegM) && RegWriteM;
        ForwardBD = (RtD != REG_ZERO) && (RtD == WriteRegM) && RegWriteM;
    end

    // Stall terms: load-use, branch waiting on E result or M load, MDU busy
    always_comb begin
        hit_e_s    = RegWriteE && (WriteRegE != REG_ZERO) &&
                     ((WriteRegE == RsD) || (WriteRegE == RtD));
        hit_m_s    = MemtoRegM && (WriteRegM != REG_ZERO) &&
                     ((WriteRegM == RsD) || (WriteRegM == RtD));
        lwstall_s  = MemtoRegE && (RtE != REG_ZERO) && ((RsD == RtE) || (RtD == RtE));
        brstall_s  = BranchD && (hit_e_s || hit_m_s);
        mdustall_s = MduUseD && (MduBusy || MduStartE);
        stall_s    = lwstall_s || brstall_s || mdustall_s;
    end

    // Pipeline control: a stalled D bubbles E; a taken branch squashes F only if D advances
    always_comb begin
        StallF = stall_s;
        StallD = stall_s;
        FlushE = stall_s;
        FlushD = BranchTakenD && !stall_s;
    end

    // MDU countdown next state: issue (re)loads latency, else decrement to zero
    always_comb begin
        mdu_cnt_d = mdu_cnt_q;
        if (MduStartE) begin
            mdu_cnt_d = MDU_LOAD;
        end else if (mdu_cnt_q != {MDU_CNT_W{1'b0}}) begin
            mdu_cnt_d = mdu_cnt_q - MDU_CNT_W'(1);
        end else begin
            mdu_cnt_d = {MDU_CNT_W{1'b0}};
        end
    end

    // MDU countdown register; reset abandons any in-flight operation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mdu_cnt_q <= {MDU_CNT_W{1'b0}};
        end else begin
            mdu_cnt_q <= mdu_cnt_d;
        end
    end

    assign MduBusy = (mdu_cnt_q != {MDU_CNT_W{1'b0}});

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;

    // Perf counter next state: clear wins over increment, saturate at all-ones
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (PerfClr) begin
            stall_cnt_d = {CNT_W{1'b0}};
            flush_cnt_d = {CNT_W{1'b0}};
        end else begin
            if (StallD && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
            if (FlushD && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end else begin
                flush_cnt_d = flush_cnt_q;
            end
        end
    end

    // Perf counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`endif

endmodule
